// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmit path between N requesters, one whole packet at a
//   time. A packet is sent as HEADER ({HDR_TAG, owner}), payload bytes, then a
//   CHECKSUM byte chosen so the 8-bit sum of the whole packet is zero.
//   Byte writes are spaced at least GAP clocks apart so the shallow UART TX
//   FIFO never overruns, including across packet boundaries.
//
// Ports
//   CLK_50MHZ  in   1    system clock, rising edge
//   RST        in   1    asynchronous, active-high reset
//   REQ        in   N    requester i has a packet (held until its LAST is ACKed)
//   DATA       in   8N   payload byte of requester i on DATA[8i+7:8i]
//   LAST       in   N    current DATA byte of requester i is its final byte
//   GNT        out  N    one-hot owner of the packet in progress
//   ACK        out  N    one-cycle pulse: owner's DATA byte consumed
//   TX_DATA    out  8    byte to UART DATA_IN
//   TX_WR      out  1    one-cycle write strobe to UART TRG_WRITE
//   TX_RDY     in   1    downstream may accept a byte
//   BUSY       out  1    packet in progress
//   ABORT      out  1    one-cycle pulse: packet closed early
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned GAP     = 4340,
    parameter int unsigned MAX_LEN = 16,
    parameter logic [3:0]  HDR_TAG = 4'hA
) (
    input  logic           CLK_50MHZ,
    input  logic           RST,
    input  logic [N-1:0]   REQ,
    input  logic [8*N-1:0] DATA,
    input  logic [N-1:0]   LAST,
    output logic [N-1:0]   GNT,
    output logic [N-1:0]   ACK,
    output logic [7:0]     TX_DATA,
    output logic           TX_WR,
    input  logic           TX_RDY,
    output logic           BUSY,
    output logic           ABORT
);

    localparam int unsigned GW         = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);
    localparam logic [7:0] MAX_LEN_M1  = 8'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_SUM
    } state_t;

    state_t         r_state;
    logic [3:0]     r_owner;
    logic [3:0]     r_rr_ptr;
    logic [GW-1:0]  r_gap_cnt;
    logic [7:0]     r_sum;
    logic [7:0]     r_len;
    logic [N-1:0]   r_gnt;
    logic [N-1:0]   r_ack;
    logic [7:0]     r_tx_data;
    logic           r_tx_wr;
    logic           r_abort;

    logic           w_slot;
    logic           w_hit;
    logic [3:0]     w_hit_idx;
    logic [N-1:0]   w_hit_oh;
    logic [3:0]     w_next_rr;
    logic           w_req_g;
    logic           w_last_g;
    logic [7:0]     w_data_g;
    logic [N-1:0]   w_own_oh;
    logic [7:0]     w_hdr;
    logic           w_len_done;

    // Round-robin search: outer loop walks priority order starting at
    // r_rr_ptr, inner loop picks the matching request bit with a constant
    // index so no variable-width select is needed.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_hit_oh  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!w_hit && REQ[j] && (j == (32'(r_rr_ptr) + k) % N)) begin
                    w_hit       = 1'b1;
                    w_hit_idx   = 4'(j);
                    w_hit_oh[j] = 1'b1;
                end
            end
        end
    end

    assign w_next_rr = 4'((32'(w_hit_idx) + 32'd1) % N);

    // Select the current owner's request, last flag and payload byte.
    always_comb begin
        w_req_g  = 1'b0;
        w_last_g = 1'b0;
        w_data_g = '0;
        w_own_oh = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_owner == 4'(i)) begin
                w_req_g     = REQ[i];
                w_last_g    = LAST[i];
                w_data_g    = DATA[8*i +: 8];
                w_own_oh[i] = 1'b1;
            end
        end
    end

    assign w_hdr      = {HDR_TAG, r_owner};
    assign w_slot     = (r_state != S_IDLE) && TX_RDY && (r_gap_cnt == '0);
    assign w_len_done = (r_len == MAX_LEN_M1);

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_gap_cnt <= '0;
            r_sum     <= '0;
            r_len     <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_tx_data <= '0;
            r_tx_wr   <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_tx_wr <= 1'b0;
            r_abort <= 1'b0;

            // A slot in DATA with the owner's REQ gone writes nothing, so the
            // pacing counter is only reloaded when a byte actually goes out.
            if (w_slot && !(r_state == S_DATA && !w_req_g)) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_gnt    <= w_hit_oh;
                        r_owner  <= w_hit_idx;
                        r_rr_ptr <= w_next_rr;
                        r_sum    <= '0;
                        r_len    <= '0;
                        r_state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_slot) begin
                        r_tx_data <= w_hdr;
                        r_tx_wr   <= 1'b1;
                        r_sum     <= r_sum + w_hdr;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_slot) begin
                        if (w_req_g) begin
                            r_tx_data <= w_data_g;
                            r_tx_wr   <= 1'b1;
                            r_ack     <= w_own_oh;
                            r_sum     <= r_sum + w_data_g;
                            r_len     <= r_len + 8'd1;
                            if (w_last_g || w_len_done) begin
                                r_state <= S_SUM;
                            end
                            if (w_len_done && !w_last_g) begin
                                r_abort <= 1'b1;
                            end
                        end else begin
                            r_abort <= 1'b1;
                            r_state <= S_SUM;
                        end
                    end
                end
                S_SUM: begin
                    if (w_slot) begin
                        r_tx_data <= (~r_sum) + 8'd1;
                        r_tx_wr   <= 1'b1;
                        r_gnt     <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign GNT     = r_gnt;
    assign ACK     = r_ack;
    assign TX_DATA = r_tx_data;
    assign TX_WR   = r_tx_wr;
    assign BUSY    = (r_state != S_IDLE);
    assign ABORT   = r_abort;

endmodule
